// File: rtl/exe_stage_unit.sv
// Execute stage: Val2 generation, ALU, branch target, NZCV status and the EX/MEM register.
// Latency: branch outputs combinational; ALU result/controls/status registered, 1 cycle.
// Backpressure: freeze holds the EX/MEM register and status; branch outputs keep following inputs.
module exe_stage_unit #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic [DW-1:0] pc_in,
  input  logic [3:0]    exe_cmd,
  input  logic          mem_r_en_in,
  input  logic          mem_w_en_in,
  input  logic          wb_en_in,
  input  logic          b_in,
  input  logic          s_in,
  input  logic          carry_in,
  input  logic [DW-1:0] val_rn,
  input  logic [DW-1:0] val_rm,
  input  logic          imm_in,
  input  logic [11:0]   shift_operand,
  input  logic [23:0]   signed_imm_24,
  input  logic [3:0]    dest_in,
  output logic          branch_taken,
  output logic [DW-1:0] branch_addr,
  output logic [3:0]    status_out,
  output logic [DW-1:0] alu_res,
  output logic [DW-1:0] st_val,
  output logic [3:0]    dest_out,
  output logic          wb_en_out,
  output logic          mem_r_en_out,
  output logic          mem_w_en_out
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  // Rotate right; an amount of zero must not produce a 32-bit left shift.
  function automatic logic [DW-1:0] ror32(input logic [DW-1:0] x, input logic [4:0] n);
    if (n == 5'd0) return x;
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  // Status register and EX/MEM register state
  logic [3:0]    status_q, status_d;
  logic [DW-1:0] alu_res_q, st_val_q;
  logic [3:0]    dest_q;
  logic          wb_en_q, mem_r_en_q, mem_w_en_q;

  logic [DW-1:0] val2;
  logic [4:0]    sh_amt;
  logic [DW-1:0] imm_src;

  logic [DW-1:0] add_b;
  logic          add_cin;
  logic [DW:0]   add_sum;
  logic [DW-1:0] alu_val;
  logic          cmd_ok;
  logic          arith;
  logic          flag_c, flag_v;

  // Branch target: PC+4 plus the sign-extended word offset, wrapping mod 2^32
  assign branch_taken = b_in;
  assign branch_addr  = pc_in + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};

  // Val2: rotated 8-bit immediate, sign-extended memory offset, or shifted Rm
  always_comb begin
    val2    = '0;
    sh_amt  = shift_operand[11:7];
    imm_src = {24'b0, shift_operand[7:0]};
    if (imm_in) begin
      val2 = ror32(imm_src, {shift_operand[11:8], 1'b0});
    end else if (mem_r_en_in || mem_w_en_in) begin
      val2 = {{20{shift_operand[11]}}, shift_operand};
    end else begin
      unique case (shift_operand[6:5])
        2'b00:   val2 = val_rm << sh_amt;
        2'b01:   val2 = val_rm >> sh_amt;
        2'b10:   val2 = DW'($signed(val_rm) >>> sh_amt);
        default: val2 = ror32(val_rm, sh_amt);
      endcase
    end
  end

  // Shared 33-bit adder: subtraction is Rn + ~Val2 + cin, so bit 32 is already NOT-borrow
  assign add_sum = {1'b0, val_rn} + {1'b0, add_b} + {{DW{1'b0}}, add_cin};

  // ALU command decode and result/flag selection
  always_comb begin
    add_b   = val2;
    add_cin = 1'b0;
    alu_val = '0;
    cmd_ok  = 1'b1;
    arith   = 1'b0;
    unique case (exe_cmd)
      CMD_MOV: alu_val = val2;
      CMD_MVN: alu_val = ~val2;
      CMD_ADD: begin arith = 1'b1; end
      CMD_ADC: begin arith = 1'b1; add_cin = carry_in; end
      CMD_SUB: begin arith = 1'b1; add_b = ~val2; add_cin = 1'b1; end
      CMD_SBC: begin arith = 1'b1; add_b = ~val2; add_cin = carry_in; end
      CMD_AND: alu_val = val_rn & val2;
      CMD_ORR: alu_val = val_rn | val2;
      CMD_EOR: alu_val = val_rn ^ val2;
      default: cmd_ok = 1'b0;
    endcase
    if (arith) alu_val = add_sum[DW-1:0];
  end

  // NZCV next value; logic ops keep the previous C and V
  always_comb begin
    flag_c = status_q[1];
    flag_v = status_q[0];
    if (arith) begin
      flag_c = add_sum[DW];
      flag_v = (val_rn[DW-1] == add_b[DW-1]) && (add_sum[DW-1] != val_rn[DW-1]);
    end
    status_d = {alu_val[DW-1], (alu_val == '0), flag_c, flag_v};
  end

  // EX/MEM and status registers: reset beats freeze; status only updates on valid S-commands
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= '0;
      alu_res_q  <= '0;
      st_val_q   <= '0;
      dest_q     <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
    end else if (!freeze) begin
      alu_res_q  <= alu_val;
      st_val_q   <= val_rm;
      dest_q     <= dest_in;
      wb_en_q    <= wb_en_in;
      mem_r_en_q <= mem_r_en_in;
      mem_w_en_q <= mem_w_en_in;
      if (s_in && cmd_ok) status_q <= status_d;
    end
  end

  assign status_out   = status_q;
  assign alu_res      = alu_res_q;
  assign st_val       = st_val_q;
  assign dest_out     = dest_q;
  assign wb_en_out    = wb_en_q;
  assign mem_r_en_out = mem_r_en_q;
  assign mem_w_en_out = mem_w_en_q;

endmodule

// File: tb/tb_exe_stage_unit.sv
// Bench for exe_stage_unit: directed vectors with literal expectations plus randomized traffic.
// A behavioural model (64-bit integer arithmetic) predicts registered outputs each cycle.
// Outputs are compared on the falling edge; directed literals are checked 1 time unit after the rising edge.
module tb_exe_stage_unit;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic [31:0] pc_in;
  logic [3:0]  exe_cmd;
  logic        mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, carry_in;
  logic [31:0] val_rn, val_rm;
  logic        imm_in;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest_in;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status_out;
  logic [31:0] alu_res, st_val;
  logic [3:0]  dest_out;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out;

  int checks = 0;
  int failures = 0;

  exe_stage_unit #(.DW(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in), .exe_cmd(exe_cmd),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
    .b_in(b_in), .s_in(s_in), .carry_in(carry_in), .val_rn(val_rn), .val_rm(val_rm),
    .imm_in(imm_in), .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
    .dest_in(dest_in), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .status_out(status_out), .alu_res(alu_res), .st_val(st_val), .dest_out(dest_out),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  function automatic logic [31:0] m_val2(input logic imm, input logic mem, input logic [11:0] so,
                                         input logic [31:0] rm);
    logic [63:0] dbl;
    logic [31:0] r;
    int amt, v;
    if (imm) begin
      dbl = {24'b0, so[7:0], 24'b0, so[7:0]};
      dbl = dbl >> (2 * int'(so[11:8]));
      return dbl[31:0];
    end
    if (mem) begin
      v = int'(so);
      if (so[11]) v = v - 4096;
      return 32'(v);
    end
    amt = int'(so[11:7]);
    r = rm;
    case (so[6:5])
      2'b00: r = rm << amt;
      2'b01: r = rm >> amt;
      2'b10: for (int i = 0; i < amt; i++) r = {r[31], r[31:1]};
      default: begin dbl = {rm, rm} >> amt; r = dbl[31:0]; end
    endcase
    return r;
  endfunction

  task automatic m_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                       input logic c, input logic [3:0] old, output logic [31:0] res,
                       output logic [3:0] st, output logic known);
    longint unsigned a, b, u;
    longint sa, sb, s;
    logic cf, vf;
    a = rn; b = v2; sa = $signed(rn); sb = $signed(v2);
    cf = old[1]; vf = old[0]; known = 1'b1; res = '0;
    case (cmd)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd2, 4'd3: begin
        u = a + b + ((cmd == 4'd3) ? 64'(c) : 64'd0);
        s = sa + sb + ((cmd == 4'd3) ? 64'(c) : 64'sd0);
        res = u[31:0]; cf = (u > 64'hFFFF_FFFF); vf = (s > SMAX) || (s < SMIN);
      end
      4'd4, 4'd5: begin
        u = (cmd == 4'd5 && !c) ? 64'd1 : 64'd0;
        s = sa - sb - longint'(u);
        res = rn - v2 - u[31:0]; cf = (a >= b + u); vf = (s > SMAX) || (s < SMIN);
      end
      4'd6: res = rn & v2;
      4'd7: res = rn | v2;
      4'd8: res = rn ^ v2;
      default: known = 1'b0;
    endcase
    st = {res[31], res == 32'd0, cf, vf};
  endtask

  logic        m_valid = 1'b0;
  logic [31:0] e_alu, e_st;
  logic [3:0]  e_dest, e_status;
  logic        e_wb, e_mr, e_mw;

  always @(posedge clk) begin
    logic [31:0] v2, res;
    logic [3:0]  nst;
    logic        known;
    if (rst) begin
      m_valid = 1'b1;
      e_alu = '0; e_st = '0; e_dest = '0; e_status = '0;
      e_wb = 1'b0; e_mr = 1'b0; e_mw = 1'b0;
    end else if (!freeze) begin
      v2 = m_val2(imm_in, mem_r_en_in | mem_w_en_in, shift_operand, val_rm);
      m_alu(exe_cmd, val_rn, v2, carry_in, e_status, res, nst, known);
      e_alu = res; e_st = val_rm; e_dest = dest_in;
      e_wb = wb_en_in; e_mr = mem_r_en_in; e_mw = mem_w_en_in;
      if (s_in && known) e_status = nst;
    end
  end

  // Compare process: registered outputs against the model, branch outputs against current inputs
  always @(negedge clk) begin
    int off;
    if (m_valid) begin
      off = int'(signed_imm_24);
      if (signed_imm_24[23]) off = off - (1 << 24);
      chk("cyc_alu_res", alu_res, e_alu);
      chk("cyc_st_val", st_val, e_st);
      chk("cyc_dest", 32'(dest_out), 32'(e_dest));
      chk("cyc_status", 32'(status_out), 32'(e_status));
      chk("cyc_ctrl", 32'({wb_en_out, mem_r_en_out, mem_w_en_out}), 32'({e_wb, e_mr, e_mw}));
      chk("cyc_br_taken", 32'(branch_taken), 32'(b_in));
      chk("cyc_br_addr", branch_addr, pc_in + 32'(off * 4));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                    input logic imm, input logic [11:0] so, input logic s, input logic c);
    exe_cmd = cmd; val_rn = rn; val_rm = rm; imm_in = imm; shift_operand = so;
    s_in = s; carry_in = c; wb_en_in = 1'b1; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    b_in = 1'b0; dest_in = 4'd3; freeze = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b1; pc_in = '0; exe_cmd = '0; mem_r_en_in = 0; mem_w_en_in = 0;
    wb_en_in = 0; b_in = 0; s_in = 0; carry_in = 0; val_rn = '0; val_rm = '0; imm_in = 0;
    shift_operand = '0; signed_imm_24 = '0; dest_in = '0;
    tick(); tick();
    chk("reset_alu", alu_res, 32'h0);
    chk("reset_status", 32'(status_out), 32'h0);

    op(4'b0010, 32'h7FFF_FFFF, 32'h0, 1'b1, 12'h001, 1'b1, 1'b0); tick();
    chk("add_res", alu_res, 32'h8000_0000);
    chk("add_status", 32'(status_out), 32'h9);

    op(4'b0100, 32'd5, 32'd5, 1'b0, 12'h000, 1'b1, 1'b0); tick();
    chk("sub_res", alu_res, 32'h0);
    chk("sub_status", 32'(status_out), 32'h6);

    op(4'b0101, 32'd3, 32'd1, 1'b0, 12'h000, 1'b0, 1'b0); tick();
    chk("sbc_res", alu_res, 32'd1);

    op(4'b0001, 32'h0, 32'h0, 1'b1, 12'h4FF, 1'b0, 1'b0); tick();
    chk("imm_rot", alu_res, 32'hFF00_0000);

    op(4'b0001, 32'h0, 32'h8000_0000, 1'b0, 12'h240, 1'b0, 1'b0); tick();
    chk("asr4", alu_res, 32'hF800_0000);

    op(4'b0001, 32'h0, 32'h0000_000F, 1'b0, 12'h260, 1'b0, 1'b0); tick();
    chk("ror4", alu_res, 32'hF000_0000);

    op(4'b0010, 32'h40, 32'h1234, 1'b0, 12'hFFC, 1'b0, 1'b0); mem_r_en_in = 1'b1; tick();
    chk("ldr_addr", alu_res, 32'h3C);
    chk("ldr_mr", 32'(mem_r_en_out), 32'd1);
    chk("ldr_status", 32'(status_out), 32'h6);

    op(4'b0000, 32'h0, 32'h0, 1'b0, 12'h0, 1'b0, 1'b0);
    b_in = 1'b1; pc_in = 32'h100; signed_imm_24 = 24'hFFFFFE; #1;
    chk("br_addr", branch_addr, 32'hF8);
    chk("br_taken", 32'(branch_taken), 32'd1);
    tick();

    op(4'b0100, 32'd1, 32'h0, 1'b1, 12'h002, 1'b1, 1'b0); tick();
    chk("pre_frz_res", alu_res, 32'hFFFF_FFFF);
    chk("pre_frz_status", 32'(status_out), 32'h8);
    for (int i = 0; i < 3; i++) begin
      op(4'b0001, $urandom, $urandom, 1'b1, 12'(i + 1), 1'b1, 1'b1); freeze = 1'b1; tick();
      chk("frz_res", alu_res, 32'hFFFF_FFFF);
      chk("frz_status", 32'(status_out), 32'h8);
    end
    op(4'b0010, 32'd10, 32'h0, 1'b1, 12'h005, 1'b1, 1'b0); tick();
    chk("unfrz_res", alu_res, 32'hF);
    chk("unfrz_status", 32'(status_out), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      exe_cmd = 4'($urandom_range(0, 15));
      val_rn = ($urandom_range(0, 3) == 0) ? {$urandom_range(0, 1) == 1, 31'h7FFF_FFFF} : $urandom;
      val_rm = $urandom;
      imm_in = 1'($urandom_range(0, 1));
      mem_r_en_in = ($urandom_range(0, 5) == 0);
      mem_w_en_in = ($urandom_range(0, 5) == 0);
      wb_en_in = 1'($urandom_range(0, 1));
      b_in = 1'($urandom_range(0, 1));
      s_in = 1'($urandom_range(0, 1));
      carry_in = 1'($urandom_range(0, 1));
      shift_operand = 12'($urandom);
      signed_imm_24 = 24'($urandom);
      pc_in = $urandom;
      dest_in = 4'($urandom);
      tick();
    end

    op(4'b0100, 32'd0, 32'h0, 1'b1, 12'h001, 1'b1, 1'b0); tick();
    rst = 1'b1; freeze = 1'b1; tick(); tick();
    chk("rst_frz_alu", alu_res, 32'h0);
    chk("rst_frz_st", st_val, 32'h0);
    chk("rst_frz_status", 32'(status_out), 32'h0);
    chk("rst_frz_ctrl", 32'({wb_en_out, mem_r_en_out, mem_w_en_out, dest_out}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
